// File: rtl/mb_pkg.sv
// mb_pkg: shared function codes, exception codes and FSM state type for the exception engine
package mb_pkg;

   localparam logic [7:0] FC_RD_HOLD   = 8'h03;
   localparam logic [7:0] FC_RD_INPUT  = 8'h04;
   localparam logic [7:0] FC_WR_SINGLE = 8'h06;

   localparam logic [7:0] EXC_OK       = 8'h00;
   localparam logic [7:0] EXC_ILL_FUNC = 8'h01;
   localparam logic [7:0] EXC_ILL_ADDR = 8'h02;
   localparam logic [7:0] EXC_ILL_VAL  = 8'h03;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_CRC,
      CHECK,
      RESP
   } state_t;

endpackage

// File: rtl/mb_sat_counter.sv
// mb_sat_counter: event counter that sticks at all-ones instead of wrapping
module mb_sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk_in,
   input  logic         rst_n_in,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   assign count = r_count;

   // count up on inc, hold once saturated
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
         r_count <= '0;
      else if (clr)
         r_count <= '0;
      else if (inc && (r_count != '1))
         r_count <= r_count + 1'b1;
   end

endmodule

// File: rtl/mb_exception_engine.sv
// mb_exception_engine: checks CRC and frame fields of a received request and produces the exception code
module mb_exception_engine
   import mb_pkg::*;
#(
   parameter logic [15:0] HOLD_BASE  = 16'h0001,
   parameter int unsigned HOLD_NUM   = 1,
   parameter logic [15:0] INPUT_BASE = 16'h0000,
   parameter int unsigned INPUT_NUM  = 5,
   parameter int unsigned MAX_QTY    = 125,
   parameter logic [15:0] WR_MAX     = 16'h0018,
   parameter int unsigned CRC_TMO    = 64,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             rx_message_done,
   input  logic [7:0]       func_code,
   input  logic [15:0]      addr,
   input  logic [15:0]      data,
   input  logic [15:0]      crc_rx_code,
   input  logic             crc_done,
   input  logic [15:0]      crc_rx_calc,
   input  logic             resp_ready,
   output logic             exception_done,
   output logic [7:0]       exception,
   output logic             crc_error,
   output logic             timeout_error,
   output logic [CNT_W-1:0] exc_count,
   output logic [CNT_W-1:0] crc_err_count
);

   localparam int unsigned TW = $clog2(CRC_TMO + 1);

   state_t        r_state, w_next;
   logic [7:0]    r_fc;
   logic [15:0]   r_addr, r_data, r_crc_code, r_crc_calc;
   logic [TW-1:0] r_timer;
   logic [7:0]    r_exc, w_class;
   logic          r_crc_err, r_tmo;
   logic          w_capture, w_crc_take, w_timeout, w_accept;
   logic          w_crc_ok, w_check_good, w_check_bad;
   logic          w_rd;
   logic [15:0]   w_rd_base;
   logic [16:0]   w_end, w_rd_lim, w_hold_hi;

   assign w_crc_ok       = (r_crc_calc == r_crc_code);
   assign w_check_good   = (r_state == CHECK) && w_crc_ok;
   assign w_check_bad    = (r_state == CHECK) && !w_crc_ok;
   assign exception_done = (r_state == RESP);
   assign exception      = r_exc;
   assign crc_error      = r_crc_err;
   assign timeout_error  = r_tmo;

   // state register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // next state plus capture, timeout and acceptance strobes
   always_comb begin
      w_next     = r_state;
      w_capture  = 1'b0;
      w_crc_take = 1'b0;
      w_timeout  = 1'b0;
      w_accept   = 1'b0;
      case (r_state)
         IDLE: begin
            if (rx_message_done) begin
               w_capture  = 1'b1;
               w_crc_take = crc_done;
               w_next     = crc_done ? CHECK : WAIT_CRC;
            end
         end
         WAIT_CRC: begin
            if (crc_done) begin
               w_crc_take = 1'b1;
               w_next     = CHECK;
            end else if (r_timer == TW'(CRC_TMO - 1)) begin
               w_timeout = 1'b1;
               w_next    = IDLE;
            end
         end
         CHECK: w_next = w_crc_ok ? RESP : IDLE;
         RESP: begin
            if (resp_ready) begin
               w_accept = 1'b1;
               w_next   = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // classify the latched request; range sums are 17 bits so addr+data cannot wrap
   always_comb begin
      w_rd      = (r_fc == FC_RD_HOLD) || (r_fc == FC_RD_INPUT);
      w_rd_base = (r_fc == FC_RD_HOLD) ? HOLD_BASE : INPUT_BASE;
      w_rd_lim  = {1'b0, w_rd_base} + ((r_fc == FC_RD_HOLD) ? 17'(HOLD_NUM) : 17'(INPUT_NUM));
      w_end     = {1'b0, r_addr} + {1'b0, r_data};
      w_hold_hi = {1'b0, HOLD_BASE} + 17'(HOLD_NUM);
      w_class   = w_rd ?
                     (((r_data == 16'h0000) || (r_data > 16'(MAX_QTY))) ? EXC_ILL_VAL :
                      ((r_addr < w_rd_base) || (w_end > w_rd_lim))      ? EXC_ILL_ADDR : EXC_OK) :
                  (r_fc == FC_WR_SINGLE) ?
                     (((r_addr < HOLD_BASE) || ({1'b0, r_addr} >= w_hold_hi)) ? EXC_ILL_ADDR :
                      (r_data > WR_MAX)                                      ? EXC_ILL_VAL  : EXC_OK) :
                  EXC_ILL_FUNC;
   end

   // frame latches, CRC wait timer, result register and error pulses
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_fc       <= '0;
         r_addr     <= '0;
         r_data     <= '0;
         r_crc_code <= '0;
         r_crc_calc <= '0;
         r_timer    <= '0;
         r_exc      <= EXC_OK;
         r_crc_err  <= 1'b0;
         r_tmo      <= 1'b0;
      end else begin
         if (w_capture) begin
            r_fc       <= func_code;
            r_addr     <= addr;
            r_data     <= data;
            r_crc_code <= crc_rx_code;
         end
         if (w_crc_take)
            r_crc_calc <= crc_rx_calc;
         r_timer   <= (r_state == WAIT_CRC) ? r_timer + 1'b1 : '0;
         r_exc     <= w_check_good ? w_class : w_accept ? EXC_OK : r_exc;
         r_crc_err <= w_check_bad;
         r_tmo     <= w_timeout;
      end
   end

   mb_sat_counter #(.W(CNT_W)) u_exc_cnt (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .inc      (w_accept && (r_exc != EXC_OK)),
      .clr      (1'b0),
      .count    (exc_count)
   );

   mb_sat_counter #(.W(CNT_W)) u_crc_cnt (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .inc      (w_check_bad),
      .clr      (1'b0),
      .count    (crc_err_count)
   );

endmodule

// File: tb/tb_mb_exception_engine.sv
// tb_mb_exception_engine: directed and randomized checks against a frame-level reference model
module tb_mb_exception_engine;

   localparam int CRC_TMO = 64;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk_in          = 1'b0;
   logic             rst_n_in        = 1'b1;
   logic             rx_message_done = 1'b0;
   logic [7:0]       func_code       = '0;
   logic [15:0]      addr            = '0;
   logic [15:0]      data            = '0;
   logic [15:0]      crc_rx_code     = '0;
   logic             crc_done        = 1'b0;
   logic [15:0]      crc_rx_calc     = '0;
   logic             resp_ready      = 1'b0;
   logic             exception_done;
   logic [7:0]       exception;
   logic             crc_error;
   logic             timeout_error;
   logic [CNT_W-1:0] exc_count;
   logic [CNT_W-1:0] crc_err_count;

   int n_tot  = 0;
   int n_pass = 0;

   mb_exception_engine #(.CNT_W(CNT_W), .CRC_TMO(CRC_TMO)) dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .rx_message_done (rx_message_done),
      .func_code       (func_code),
      .addr            (addr),
      .data            (data),
      .crc_rx_code     (crc_rx_code),
      .crc_done        (crc_done),
      .crc_rx_calc     (crc_rx_calc),
      .resp_ready      (resp_ready),
      .exception_done  (exception_done),
      .exception       (exception),
      .crc_error       (crc_error),
      .timeout_error   (timeout_error),
      .exc_count       (exc_count),
      .crc_err_count   (crc_err_count)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [14:0] outs();
      return {exception_done, exception, crc_error, timeout_error, exc_count, crc_err_count};
   endfunction

   // exception code from the request rules, using unbounded integer sums
   function automatic int classify(int fc, int a, int d);
      int base, num;
      if (fc == 3 || fc == 4) begin
         base = (fc == 3) ? 1 : 0;
         num  = (fc == 3) ? 1 : 5;
         if (d == 0 || d > 125) return 3;
         if (a < base || a + d > base + num) return 2;
         return 0;
      end
      if (fc == 6) return (a < 1 || a >= 2) ? 2 : (d > 24) ? 3 : 0;
      return 1;
   endfunction

   function automatic logic [CNT_W-1:0] sat(logic [CNT_W-1:0] v);
      return (int'(v) == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // reference model: one pending frame, its CRC wait age, a pending verdict and a held result
   logic             m_done = 0, m_crc_p = 0, m_tmo_p = 0;
   logic [7:0]       m_exc  = 0;
   logic [CNT_W-1:0] m_ecnt = 0, m_ccnt = 0;
   bit               m_wait = 0, m_judge = 0;
   int               m_age = 0, m_fc = 0, m_addr = 0, m_data = 0, m_code = 0, m_calc = 0;

   always @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         m_done = 0; m_crc_p = 0; m_tmo_p = 0; m_exc = 0; m_ecnt = 0; m_ccnt = 0;
         m_wait = 0; m_judge = 0; m_age = 0;
      end else begin
         m_crc_p = 0;
         m_tmo_p = 0;
         if (m_done) begin
            if (resp_ready) begin
               if (m_exc != 0) m_ecnt = sat(m_ecnt);
               m_done = 0;
               m_exc  = 0;
            end
         end else if (m_judge) begin
            m_judge = 0;
            if (m_calc == m_code) begin
               m_done = 1;
               m_exc  = 8'(classify(m_fc, m_addr, m_data));
            end else begin
               m_crc_p = 1;
               m_ccnt  = sat(m_ccnt);
            end
         end else if (m_wait) begin
            if (crc_done) begin
               m_calc  = int'(crc_rx_calc);
               m_wait  = 0;
               m_judge = 1;
            end else begin
               m_age++;
               if (m_age == CRC_TMO) begin
                  m_tmo_p = 1;
                  m_wait  = 0;
               end
            end
         end else if (rx_message_done) begin
            m_fc   = int'(func_code);
            m_addr = int'(addr);
            m_data = int'(data);
            m_code = int'(crc_rx_code);
            if (crc_done) begin
               m_calc  = int'(crc_rx_calc);
               m_judge = 1;
            end else begin
               m_wait = 1;
               m_age  = 0;
            end
         end
      end
   end

   always @(negedge clk_in)
      chk("cycle", {17'd0, outs()}, {17'd0, m_done, m_exc, m_crc_p, m_tmo_p, m_ecnt, m_ccnt});

   task automatic step();
      @(posedge clk_in);
      #2;
   endtask

   task automatic set_fields(input logic [7:0] fc, input logic [15:0] a, d, code, calc);
      func_code   = fc;
      addr        = a;
      data        = d;
      crc_rx_code = code;
      crc_rx_calc = calc;
   endtask

   // capture, crc_done one cycle later, then step past the verdict cycle
   task automatic frame(input logic [7:0] fc, input logic [15:0] a, d, code, calc);
      set_fields(fc, a, d, code, calc);
      rx_message_done = 1'b1;
      step();
      rx_message_done = 1'b0;
      crc_done = 1'b1;
      step();
      crc_done = 1'b0;
      chk("verdict_cycle_quiet", exception_done, 1'b0);
      step();
   endtask

   initial begin
      int k, width, seen;
      #1 rst_n_in = 1'b0;
      #2 chk("reset_outputs", outs(), 15'd0);
      step();
      step();
      rst_n_in = 1'b1;
      step();

      resp_ready = 1'b1;
      frame(8'h03, 16'h0001, 16'h0001, 16'hAAAA, 16'hAAAA);
      chk("fc03_ok_done", exception_done, 1'b1);
      chk("fc03_ok_exc", exception, 8'h00);
      step();
      chk("fc03_accepted", exception_done, 1'b0);
      chk("fc03_counters", {exc_count, crc_err_count}, 4'h0);

      resp_ready = 1'b0;
      frame(8'h05, 16'h0001, 16'h0001, 16'h1111, 16'h1111);
      for (int i = 0; i < 10; i++) begin
         chk("hold_done", exception_done, 1'b1);
         chk("hold_exc", exception, 8'h01);
         chk("hold_cnt", exc_count, 2'd0);
         step();
      end
      resp_ready = 1'b1;
      step();
      chk("hold_released", {exception_done, exception}, 9'h000);
      chk("hold_cnt_after", exc_count, 2'd1);

      frame(8'h06, 16'h0001, 16'h0019, 16'h2222, 16'h2222);
      chk("fc06_val", exception, 8'h03);
      step();
      chk("fc06_cnt", exc_count, 2'd2);
      frame(8'h04, 16'h0003, 16'h0003, 16'h3333, 16'h3333);
      chk("fc04_range", exception, 8'h02);
      step();
      frame(8'h04, 16'h0000, 16'h0000, 16'h3333, 16'h3333);
      chk("fc04_qty0", exception, 8'h03);
      step();
      frame(8'h04, 16'hFFFF, 16'h0002, 16'h3333, 16'h3333);
      chk("fc04_nowrap", exception, 8'h02);
      step();
      chk("exc_cnt_sat", exc_count, 2'd3);

      frame(8'h03, 16'h0001, 16'h0001, 16'h4321, 16'h1234);
      chk("crc_err_pulse", crc_error, 1'b1);
      chk("crc_err_nodone", exception_done, 1'b0);
      chk("crc_err_cnt1", crc_err_count, 2'd1);
      step();
      chk("crc_err_width", crc_error, 1'b0);
      repeat (4) begin
         frame(8'h03, 16'h0001, 16'h0001, 16'h4321, 16'h1234);
         step();
      end
      chk("crc_cnt_sat", crc_err_count, 2'd3);

      set_fields(8'h03, 16'h0001, 16'h0002, 16'h5555, 16'h5555);
      rx_message_done = 1'b1;
      crc_done = 1'b1;
      step();
      rx_message_done = 1'b0;
      crc_done = 1'b0;
      step();
      chk("same_cycle_crc", {exception_done, exception}, 9'h102);
      step();

      crc_done = 1'b1;
      step();
      crc_done = 1'b0;
      step();
      step();
      chk("crc_in_idle", {exception_done, crc_error}, 2'b00);

      set_fields(8'h03, 16'h0001, 16'h0001, 16'h0005, 16'h0000);
      rx_message_done = 1'b1;
      step();
      set_fields(8'h05, 16'h0009, 16'h0000, 16'h0006, 16'h0005);
      step();
      rx_message_done = 1'b0;
      crc_done = 1'b1;
      step();
      crc_done = 1'b0;
      step();
      chk("drop_second_rx", {exception_done, exception}, 9'h100);
      step();

      set_fields(8'h03, 16'h0001, 16'h0001, 16'h7777, 16'h7777);
      rx_message_done = 1'b1;
      step();
      rx_message_done = 1'b0;
      k = 0;
      width = 0;
      seen = 0;
      for (int i = 1; i <= CRC_TMO + 4; i++) begin
         if (i == 10) rx_message_done = 1'b1;
         step();
         rx_message_done = 1'b0;
         if (timeout_error) begin
            width++;
            if (seen == 0) k = i;
            seen = 1;
         end
         if (exception_done) seen = 2;
      end
      chk("tmo_delay", k, CRC_TMO);
      chk("tmo_width", width, 1);
      chk("tmo_no_resp", seen, 1);

      resp_ready = 1'b0;
      frame(8'h05, 16'h0000, 16'h0001, 16'h8888, 16'h8888);
      chk("pre_rst_resp", exception_done, 1'b1);
      #1 rst_n_in = 1'b0;
      #1 chk("rst_in_resp", outs(), 15'd0);
      step();
      rst_n_in = 1'b1;
      resp_ready = 1'b1;
      crc_done = 1'b1;
      step();
      crc_done = 1'b0;
      seen = 0;
      repeat (4) begin
         step();
         if (exception_done || crc_error) seen = 1;
      end
      chk("rst_resp_no_later", seen, 0);

      frame(8'h04, 16'h0001, 16'h0001, 16'h9999, 16'h9998);
      step();
      set_fields(8'h03, 16'h0001, 16'h0001, 16'hABCD, 16'hABCD);
      rx_message_done = 1'b1;
      step();
      rx_message_done = 1'b0;
      step();
      #1 rst_n_in = 1'b0;
      #1 chk("rst_in_wait", outs(), 15'd0);
      step();
      rst_n_in = 1'b1;
      crc_done = 1'b1;
      step();
      crc_done = 1'b0;
      seen = 0;
      repeat (CRC_TMO + 4) begin
         step();
         if (exception_done || crc_error || timeout_error) seen = 1;
      end
      chk("rst_wait_no_later", seen, 0);

      for (int i = 0; i < 4000; i++) begin
         int thr, sel;
         thr = (i / 500) % 4 == 0 ? 2 : (i / 500) % 4 == 1 ? 5 : (i / 500) % 4 == 2 ? 30 : 100;
         rst_n_in = ($urandom_range(0, 599) != 0);
         rx_message_done = ($urandom_range(0, 3) == 0);
         crc_done = ($urandom_range(0, thr - 1) == 0);
         resp_ready = $urandom_range(0, 1) == 1;
         sel = $urandom_range(0, 5);
         func_code = sel == 0 ? 8'h03 : sel == 1 ? 8'h04 : sel == 2 ? 8'h06 :
                     sel == 3 ? 8'h05 : sel == 4 ? 8'h01 : 8'($urandom);
         sel = $urandom_range(0, 2);
         addr = sel == 0 ? 16'($urandom_range(0, 7)) : sel == 1 ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
         sel = $urandom_range(0, 3);
         data = sel == 0 ? 16'($urandom_range(0, 8)) : sel == 1 ? 16'($urandom_range(124, 126)) :
                sel == 2 ? 16'($urandom_range(23, 26)) : 16'($urandom);
         crc_rx_code = 16'($urandom);
         crc_rx_calc = ($urandom_range(0, 3) != 0) ? crc_rx_code : crc_rx_code ^ 16'h0001;
         step();
      end
      rst_n_in = 1'b1;
      rx_message_done = 1'b0;
      crc_done = 1'b0;
      step();
      step();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/mb_exception_engine.md
MB_EXCEPTION_ENGINE -- requirements
Module: mb_exception_engine

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  HOLD_BASE   16'h0001  first holding-register address
  HOLD_NUM    1         holding-register count
  INPUT_BASE  16'h0000  first input-register address
  INPUT_NUM   5         input-register count
  MAX_QTY     125       maximum read quantity for FC 03/04
  WR_MAX      16'h0018  maximum value accepted by FC 06
  CRC_TMO     64        clk_in cycles allowed between capture and crc_done
  CNT_W       16        diagnostic counter width
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk_in           in   1       clock
  rst_n_in         in   1       reset, asynchronous, active-low
  rx_message_done  in   1       one-cycle pulse; frame fields valid
  func_code        in   8       received function code
  addr             in   16      start or register address
  data             in   16      quantity (03/04) or write value (06)
  crc_rx_code      in   16      CRC carried in the frame
  crc_done         in   1       one-cycle pulse; crc_rx_calc valid
  crc_rx_calc      in   16      locally computed CRC
  resp_ready       in   1       response builder accepts the result
  exception_done   out  1       result valid; held until accepted
  exception        out  8       00 = OK, 01, 02 or 03
  crc_error        out  1       one-cycle pulse on CRC mismatch
  timeout_error    out  1       one-cycle pulse on CRC timeout
  exc_count        out  CNT_W   accepted nonzero exceptions, saturating
  crc_err_count    out  CNT_W   CRC mismatches, saturating

Function
REQ-003 The FSM SHALL use the states IDLE, WAIT_CRC, CHECK and RESP.
REQ-004 In IDLE, rx_message_done SHALL latch func_code, addr, data and crc_rx_code, then move to WAIT_CRC.
REQ-005 If crc_done coincides with the capturing rx_message_done, or arrives in WAIT_CRC, crc_rx_calc SHALL be latched and the FSM SHALL move to CHECK.
REQ-006 A crc_done seen in IDLE without rx_message_done SHALL be ignored.
REQ-007 The WAIT_CRC timer SHALL start at 0 on entry; reaching CRC_TMO without crc_done SHALL pulse timeout_error and return to IDLE with no response.
REQ-008 CHECK SHALL last exactly one cycle; on a CRC mismatch it SHALL pulse crc_error, increment crc_err_count and return to IDLE with no response.
REQ-009 With a matching CRC, the code SHALL be 01 when func_code is not 03, 04 or 06.
REQ-010 FC 03/04 SHALL give 03 when data==0 or data>MAX_QTY.
REQ-011 Otherwise FC 03/04 SHALL give 02 when addr is below the FC's base, or when the 17-bit sum addr+data exceeds base+NUM.
REQ-012 Otherwise FC 03/04 SHALL give 00.
REQ-013 FC 06 SHALL give 02 when addr is outside [HOLD_BASE, HOLD_BASE+HOLD_NUM).
REQ-014 Otherwise FC 06 SHALL give 03 when data>WR_MAX, and 00 otherwise.
REQ-015 Range arithmetic SHALL be 17-bit, so that addr+data never wraps.
REQ-016 CHECK SHALL then enter RESP, with exception_done=1 and exception valid from the cycle after CHECK.
REQ-017 In RESP both outputs SHALL hold until the cycle resp_ready=1; at the next edge exception_done SHALL be 0, exception SHALL be 00 and the FSM SHALL be in IDLE.
REQ-018 Latency from the crc_done edge to exception_done=1 SHALL be 2 cycles.
REQ-019 rx_message_done outside IDLE SHALL be dropped and SHALL NOT disturb the latched fields.
REQ-020 exc_count SHALL increment on acceptance of a nonzero exception.
REQ-021 Both counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-022 resp_ready outside RESP SHALL be ignored.

Reset
REQ-023 rst_n_in low SHALL, asynchronously and in any state, clear every output, counter, latch and timer to 0 and force IDLE.
REQ-024 A reset asserted mid-frame SHALL NOT produce a later response.

Structure
REQ-025 Package mb_pkg SHALL hold the function-code constants (03, 04, 06), the exception-code constants (00 to 03) and the state enum.
REQ-026 Sub-module mb_sat_counter (parameter W; inputs inc and clr) SHALL be instantiated twice, once per counter.
REQ-027 Classification SHALL be combinational from the latches, and registered into exception on the CHECK-to-RESP transition.

Verification
REQ-028 FC 03, addr=0001, data=0001, CRC match, resp_ready=1 -> exception_done 2 cycles after crc_done, exception=00, counters unchanged.
REQ-029 FC 04, addr=0003, data=0003 -> exception=02; FC 04, addr=0000, data=0000 -> 03; FC 04, addr=FFFF, data=0002 -> 02, with no wrap.
REQ-030 FC 06, addr=0001, data=0019 -> 03; FC 05 -> 01; resp_ready held low 10 cycles -> exception_done and exception stable for all 10, exc_count +1 only on acceptance.
REQ-031 CRC mismatch (calc=1234, code=4321) -> crc_error one-cycle pulse, crc_err_count=1, no exception_done; with CNT_W=2, five mismatches -> count=3.
REQ-032 rx_message_done with no crc_done -> timeout_error pulse exactly CRC_TMO cycles later, FSM in IDLE; a second rx_message_done during WAIT_CRC -> ignored.
REQ-033 rst_n_in pulsed low in WAIT_CRC and in RESP -> all outputs 0 immediately, and a later crc_done yields no response.
